spi_tx_feeder: RTL and testbench
================================

// Module: spi_tx_feeder
// PURPOSE
//  Byte source that sits directly upstream of the SPI slave sender. Buffers measurement
//  words from the compressive-sensing datapath in a FIFO and splits them into bytes, MSB
//  byte first. Presents the next byte on tx_data and advances on the sender's byte_sent pulse.
//  Drives tx_arm into the sender's signalReceived input, one frame of FRAME_WORDS words at a time.
// PARAMETERS
//  WORD_W       16     measurement word width; must be a multiple of 8 (BYTES = WORD_W/8)
//  DEPTH        16     FIFO depth in words; must be a power of 2
//  FRAME_WORDS  8      words per armed frame; must be >= 1
//  FILL_BYTE    8'h00  byte presented when the FIFO cannot supply data
// PORTS
//  clk            in   1                 system clock; SCK is already synchronised inside the sender
//  rst_n          in   1                 asynchronous, active-low reset
//  in_valid       in   1                 upstream word valid
//  in_data        in   WORD_W            upstream measurement word
//  in_ready       out  1                 FIFO can accept a word
//  byte_sent      in   1                 1-clk pulse from the sender: the byte in flight has been shifted out
//  tx_data        out  8                 byte the sender loads next
//  tx_arm         out  1                 enables the sender (drives its signalReceived input)
//  level          out  $clog2(DEPTH)+1   words held in the FIFO
//  frame_done     out  1                 1-clk pulse: last byte of a frame consumed
//  underflow      out  1                 sticky: a FILL_BYTE was consumed inside a frame
//  clr_underflow  in   1                 synchronous clear for underflow
// BEHAVIOUR
//  Reset values
//   - in_ready=0 while rst_n=0, 1 after reset; tx_data=FILL_BYTE; tx_arm=0; level=0.
//   - frame_done=0; underflow=0; FIFO pointers, byte index and word counter all 0.
//  FIFO
//   - Push when in_valid && in_ready. in_ready = !full.
//   - On full, no push is accepted even if a pop occurs in the same cycle.
//   - Pointers have an extra wrap bit: full = MSBs differ and the rest are equal.
//   - level = wr_ptr - rd_ptr (modulo 2^(clog2(DEPTH)+1)). level updates 1 clk after push/pop.
//  Byte select
//   - byte_idx (0..BYTES-1) selects head[WORD_W-1-8*byte_idx -: 8].
//   - tx_data is registered and reloaded every clk:
//       = selected head byte if FIFO not empty,
//       = FILL_BYTE if FIFO empty.
//   - Latency: tx_data reflects a pop or push 1 clk after the edge that caused it.
//     The sender loads 2 clks after byte_sent, so this is always in time.
//  FSM (2 states)
//   - IDLE: tx_arm=0; byte_sent is ignored.
//       -> ARMED when level >= 1; clear word_cnt and byte_idx.
//   - ARMED: tx_arm=1. On byte_sent:
//       * FIFO not empty: byte_idx++.
//         If byte_idx == BYTES-1: pop, byte_idx=0, word_cnt++.
//         If word_cnt == FRAME_WORDS-1: pulse frame_done, go to IDLE.
//       * FIFO empty: set underflow. byte_idx and word_cnt do not advance,
//         so the fill byte does not count toward the frame.
//  Simultaneous events
//   - A push and a pop in the same clk are both performed (level unchanged).
//   - A push into an empty FIFO on the same clk as byte_sent in ARMED still flags underflow,
//     because the fill byte was the byte consumed.
//   - clr_underflow and a new underflow in the same clk: set wins.
//   - frame_done and level>=1 on the same clk: IDLE for exactly 1 clk, then re-arm.
//  Reset mid-frame: all state is dropped asynchronously, including FIFO contents;
//   no partial word is preserved.
// STRUCTURE
//  - Shared package: FSM state enum (ST_IDLE, ST_ARMED) and a width helper for
//    BYTES = WORD_W/8 and log2 of DEPTH.
//  - One sub-module: sync_fifo (WIDTH, DEPTH) with push/pop/full/empty/level/head.
//    Head is read combinationally. FSM and byte splitting stay in the top level.
// TESTING
//  1. Reset: assert rst_n=0 mid-frame -> tx_arm=0, tx_data=8'h00, level=0, in_ready=1 after release.
//  2. Push 16'hA55A, then pulse byte_sent twice -> tx_data 8'hA5 then 8'h5A; pop after the 2nd pulse; level 1->0.
//  3. FRAME_WORDS=2, push 3 words, 4 byte_sent pulses
//     -> frame_done on the 4th pulse, 1 clk in IDLE, re-arm with level=1.
//  4. Underflow: armed with 1 word, 3 byte_sent pulses
//     -> 3rd byte is 8'h00, underflow=1, word_cnt stays 1; clr_underflow -> 0.
//  5. Full: push DEPTH words -> in_ready=0; a pop plus a push attempt in the same clk -> level=DEPTH-1.
//     Pointer wrap: 40 words streamed -> byte order intact.
//  6. Random push/byte_sent traffic vs a scoreboard model -> byte stream matches MSB-first split; no loss or duplication.

Source files
------------

// File: rtl/spi_tx_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_feeder_pkg
//  Description : Shared types and width helpers for the SPI transmit feeder.
//                Provides the feeder FSM state encoding and small constant
//                functions that derive byte counts and index widths from the
//                word and FIFO parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_tx_feeder_pkg;

    // Two-state frame controller: waiting for data, or feeding the sender.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    // Number of whole bytes in a measurement word.
    function automatic int calc_bytes(input int word_w);
        return word_w / 8;
    endfunction

    // Ceiling log2; calc_log2(1) = 0.
    function automatic int calc_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of an index/counter that counts 0..n-1, never narrower than 1 bit.
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? calc_log2(n) : 1;
    endfunction

endpackage : spi_tx_feeder_pkg
`default_nettype wire

// File: rtl/spi_tx_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_feeder_if
//  Description : Bundles the two handshakes of the SPI transmit feeder:
//                the upstream word stream (in_valid/in_data/in_ready) and the
//                byte-level link to the SPI slave sender
//                (byte_sent/tx_data/tx_arm).
//  Ports       : slave  - feeder side (receives words, drives the sender)
//                master - environment side (supplies words, acts as sender)
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_tx_feeder_if #(
    parameter int WORD_W = 16
) ();

    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              byte_sent;
    logic [7:0]        tx_data;
    logic              tx_arm;

    modport master (
        output in_valid,
        output in_data,
        output byte_sent,
        input  in_ready,
        input  tx_data,
        input  tx_arm
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  byte_sent,
        output in_ready,
        output tx_data,
        output tx_arm
    );

endinterface : spi_tx_feeder_if
`default_nettype wire

// File: rtl/spi_tx_feeder_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_feeder_sync_fifo
//  Description : Single-clock FIFO used by the SPI transmit feeder.
//                Pointers carry one extra wrap bit so full and empty are
//                distinguished without a separate counter. The head word is
//                read combinationally from the storage array.
//  Ports       : clk, rst_n       - clock, asynchronous active-low reset
//                push, din        - write request and data (ignored on full)
//                pop              - read request (ignored on empty)
//                head             - word at the read pointer
//                full, empty      - occupancy flags
//                level            - words held (wr_ptr - rd_ptr)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_feeder_sync_fifo
    import spi_tx_feeder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         din,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         head,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   level
);

    localparam int c_AW = calc_log2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses writes even when a read happens on the same edge.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign level = r_wr_ptr - r_rd_ptr;
    assign head  = r_mem[r_rd_ptr[c_AW-1:0]];

    // Storage is not reset: dropping the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : spi_tx_feeder_sync_fifo
`default_nettype wire

// File: rtl/spi_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_feeder
//  Description : Byte source sitting directly upstream of the SPI slave
//                sender. Buffers measurement words in a FIFO, splits the head
//                word into bytes MSB byte first, presents the next byte on
//                tx_data and advances on each byte_sent pulse. tx_arm enables
//                the sender for one frame of FRAME_WORDS words at a time.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                bus (slave)     - in_valid/in_data/in_ready word input,
//                                  byte_sent/tx_data/tx_arm sender link
//                level           - words held in the FIFO
//                frame_done      - 1-clk pulse, last byte of a frame consumed
//                underflow       - sticky, a fill byte was consumed in a frame
//                clr_underflow   - synchronous clear for underflow
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_feeder
    import spi_tx_feeder_pkg::*;
#(
    parameter int         WORD_W      = 16,     // multiple of 8, matches bus
    parameter int         DEPTH       = 16,     // power of 2
    parameter int         FRAME_WORDS = 8,      // >= 1
    parameter logic [7:0] FILL_BYTE   = 8'h00
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    spi_tx_feeder_if.slave              bus,
    output logic      [$clog2(DEPTH):0] level,
    output logic                        frame_done,
    output logic                        underflow,
    input  wire logic                   clr_underflow
);

    localparam int c_BYTES = calc_bytes(WORD_W);
    localparam int c_IDX_W = calc_idx_w(c_BYTES);
    localparam int c_CNT_W = calc_idx_w(FRAME_WORDS);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]      w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_level;
    logic                   w_push;
    logic                   w_pop;

    // Registered control state
    state_t                 r_state;
    logic [c_IDX_W-1:0]     r_byte_idx;
    logic [c_CNT_W-1:0]     r_word_cnt;
    logic                   r_tx_arm;
    logic                   r_frame_done;
    logic                   r_underflow;
    logic [7:0]             r_tx_data;
    logic                   r_alive;

    // Byte splitting
    logic [c_IDX_W+2:0]     w_shamt;
    logic [WORD_W-1:0]      w_shifted;
    logic [7:0]             w_byte_sel;
    logic                   w_consume;
    logic                   w_last_byte;
    logic                   w_last_word;

    // r_alive keeps in_ready low throughout reset and rises on the first
    // clock after release.
    assign bus.in_ready = r_alive && !w_full;
    assign w_push       = bus.in_valid && bus.in_ready;

    // byte_sent only counts while a frame is armed.
    assign w_consume   = (r_state == ST_ARMED) && bus.byte_sent;
    assign w_last_byte = (r_byte_idx == c_IDX_W'(c_BYTES - 1));
    assign w_last_word = (r_word_cnt == c_CNT_W'(FRAME_WORDS - 1));
    assign w_pop       = w_consume && !w_empty && w_last_byte;

    spi_tx_feeder_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (bus.in_data),
        .pop   (w_pop),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // Shifting the head left by 8*byte_idx brings the selected byte to the
    // top, which is head[WORD_W-1-8*byte_idx -: 8].
    assign w_shamt    = {r_byte_idx, 3'b000};
    assign w_shifted  = w_head << w_shamt;
    assign w_byte_sel = w_shifted[WORD_W-1 -: 8];

    // ------------------------------------------------------------------
    // Frame controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_byte_idx   <= '0;
            r_word_cnt   <= '0;
            r_tx_arm     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx_arm <= 1'b0;
                    if (w_level != '0) begin
                        r_state    <= ST_ARMED;
                        r_tx_arm   <= 1'b1;
                        r_byte_idx <= '0;
                        r_word_cnt <= '0;
                    end
                end
                ST_ARMED: begin
                    // A fill byte consumed on an empty FIFO leaves the
                    // position untouched so it does not count toward the frame.
                    if (w_consume && !w_empty) begin
                        if (w_last_byte) begin
                            r_byte_idx <= '0;
                            if (w_last_word) begin
                                r_word_cnt   <= '0;
                                r_frame_done <= 1'b1;
                                r_tx_arm     <= 1'b0;
                                r_state      <= ST_IDLE;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tx_arm <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Underflow flag: setting wins over a simultaneous clear. Emptiness is
    // judged before any same-edge push, since the fill byte is what the
    // sender consumed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
        end else if (w_consume && w_empty) begin
            r_underflow <= 1'b1;
        end else if (clr_underflow) begin
            r_underflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Presented byte, reloaded every clock. It lags a push/pop by one clock;
    // the sender loads two clocks after byte_sent so it always sees the
    // updated value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data <= FILL_BYTE;
            r_alive   <= 1'b0;
        end else begin
            r_tx_data <= w_empty ? FILL_BYTE : w_byte_sel;
            r_alive   <= 1'b1;
        end
    end

    assign bus.tx_data = r_tx_data;
    assign bus.tx_arm  = r_tx_arm;
    assign level       = w_level;
    assign frame_done  = r_frame_done;
    assign underflow   = r_underflow;

endmodule : spi_tx_feeder
`default_nettype wire

// File: tb/tb_spi_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_tx_feeder
//  Description : Self-checking bench for spi_tx_feeder. A byte-queue model
//                tracks what the feeder holds and what it should present;
//                scenario tasks drive directed and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_tx_feeder;

    localparam int         WORD_W      = 16;
    localparam int         DEPTH       = 16;
    localparam int         FRAME_WORDS = 2;
    localparam int         BYTES       = WORD_W / 8;
    localparam logic [7:0] FILL        = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr_underflow;
    logic [4:0] level;
    logic       frame_done;
    logic       underflow;

    int n_checks = 0;
    int n_pass   = 0;

    spi_tx_feeder_if #(.WORD_W(WORD_W)) bus ();

    spi_tx_feeder #(
        .WORD_W      (WORD_W),
        .DEPTH       (DEPTH),
        .FRAME_WORDS (FRAME_WORDS),
        .FILL_BYTE   (FILL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .level         (level),
        .frame_done    (frame_done),
        .underflow     (underflow),
        .clr_underflow (clr_underflow)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the bytes still owed to the sender, in order.
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    bit         m_armed;
    bit         m_under;
    bit         m_alive;
    bit         m_fd;
    bit         m_pushed;
    int         m_frame_bytes;
    logic [7:0] m_txd;

    function automatic int m_words();
        return (m_q.size() + BYTES - 1) / BYTES;
    endfunction

    function automatic bit m_ready();
        return m_alive && (m_words() < DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_armed       = 0;
        m_under       = 0;
        m_alive       = 0;
        m_fd          = 0;
        m_pushed      = 0;
        m_frame_bytes = 0;
        m_txd         = FILL;
    endtask

    // Advance one clock with the inputs currently driven, updating the model.
    task automatic tick();
        bit                push_ok;
        bit                had_words;
        bit                set_u;
        logic [WORD_W-1:0] d;
        push_ok   = bus.in_valid && m_ready();
        had_words = m_words() >= 1;
        m_txd     = (m_q.size() != 0) ? m_q[0] : FILL;
        m_fd      = 0;
        set_u     = 0;
        if (m_armed) begin
            if (bus.byte_sent) begin
                if (m_q.size() != 0) begin
                    void'(m_q.pop_front());
                    m_frame_bytes++;
                    if (m_frame_bytes == FRAME_WORDS * BYTES) begin
                        m_fd    = 1;
                        m_armed = 0;
                    end
                end else begin
                    set_u = 1;
                end
            end
        end else if (had_words) begin
            m_armed       = 1;
            m_frame_bytes = 0;
        end
        if (set_u) m_under = 1;
        else if (clr_underflow) m_under = 0;
        if (push_ok) begin
            d = bus.in_data;
            for (int b = 0; b < BYTES; b++) m_q.push_back(d[WORD_W-1-8*b -: 8]);
        end
        m_pushed = push_ok;
        m_alive  = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.in_valid  = 1'b0;
        bus.byte_sent = 1'b0;
        clr_underflow = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++; if (bus.tx_arm !== 1'b0) $display("FAIL reset_tx_arm got %b want 0", bus.tx_arm); else n_pass++;
        n_checks++; if (bus.tx_data !== FILL) $display("FAIL reset_tx_data got %h want %h", bus.tx_data, FILL); else n_pass++;
        n_checks++; if (level !== 5'd0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready_low got %b want 0", bus.in_ready); else n_pass++;
        n_checks++; if (frame_done !== 1'b0 || underflow !== 1'b0)
            $display("FAIL reset_flags got fd=%b uf=%b want 0/0", frame_done, underflow); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_high got %b want 1", bus.in_ready); else n_pass++;

        // Mid-frame asynchronous reset drops everything
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234; tick();
        bus.in_data  = 16'h5678; tick();
        bus.in_valid = 1'b0; tick(); tick();
        n_checks++; if (bus.tx_arm !== 1'b1) $display("FAIL midframe_armed got %b want 1", bus.tx_arm); else n_pass++;
        bus.byte_sent = 1'b1; tick();
        bus.byte_sent = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (bus.tx_arm !== 1'b0) $display("FAIL midreset_tx_arm got %b want 0", bus.tx_arm); else n_pass++;
        n_checks++; if (level !== 5'd0) $display("FAIL midreset_level got %0d want 0", level); else n_pass++;
        n_checks++; if (bus.tx_data !== FILL) $display("FAIL midreset_tx_data got %h want %h", bus.tx_data, FILL); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.in_ready !== 1'b1 || level !== 5'd0)
            $display("FAIL midreset_release got rdy=%b lvl=%0d want 1/0", bus.in_ready, level); else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_split();
        apply_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hA55A;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (level !== 5'd1) $display("FAIL split_level_push got %0d want 1", level); else n_pass++;
        tick();
        n_checks++; if (bus.tx_arm !== 1'b1) $display("FAIL split_arm got %b want 1", bus.tx_arm); else n_pass++;
        n_checks++; if (bus.tx_data !== 8'hA5) $display("FAIL split_byte0 got %h want a5", bus.tx_data); else n_pass++;
        bus.byte_sent = 1'b1; tick(); bus.byte_sent = 1'b0;
        tick();
        n_checks++; if (bus.tx_data !== 8'h5A) $display("FAIL split_byte1 got %h want 5a", bus.tx_data); else n_pass++;
        n_checks++; if (level !== 5'd1) $display("FAIL split_level_mid got %0d want 1", level); else n_pass++;
        bus.byte_sent = 1'b1; tick(); bus.byte_sent = 1'b0;
        n_checks++; if (level !== 5'd0) $display("FAIL split_level_pop got %0d want 0", level); else n_pass++;
        tick();
        n_checks++; if (bus.tx_data !== FILL) $display("FAIL split_fill got %h want %h", bus.tx_data, FILL); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL split_no_underflow got %b want 0", underflow); else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_frame();
        logic [WORD_W-1:0] w [3];
        logic [7:0]        exp_b;
        apply_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w[i] = WORD_W'($urandom);
            bus.in_data = w[i];
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        for (int p = 0; p < 4; p++) begin
            exp_b = 8'(w[p / BYTES] >> (8 * (BYTES - 1 - (p % BYTES))));
            n_checks++; if (bus.tx_data !== exp_b)
                $display("FAIL frame_byte%0d got %h want %h", p, bus.tx_data, exp_b); else n_pass++;
            bus.byte_sent = 1'b1; tick(); bus.byte_sent = 1'b0;
            n_checks++; if (frame_done !== (p == 3))
                $display("FAIL frame_done_pulse%0d got %b want %b", p, frame_done, (p == 3)); else n_pass++;
            if (p < 3) tick();
        end
        n_checks++; if (bus.tx_arm !== 1'b0) $display("FAIL frame_idle got %b want 0", bus.tx_arm); else n_pass++;
        tick();
        n_checks++; if (bus.tx_arm !== 1'b1 || level !== 5'd1 || frame_done !== 1'b0)
            $display("FAIL frame_rearm got arm=%b lvl=%0d fd=%b want 1/1/0", bus.tx_arm, level, frame_done); else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_underflow();
        apply_reset();
        bus.in_valid = 1'b1; bus.in_data = 16'hC3E1; tick();
        bus.in_valid = 1'b0; tick();
        bus.byte_sent = 1'b1; tick(); bus.byte_sent = 1'b0; tick();
        bus.byte_sent = 1'b1; tick(); bus.byte_sent = 1'b0; tick();
        n_checks++; if (underflow !== 1'b0) $display("FAIL uf_before got %b want 0", underflow); else n_pass++;
        n_checks++; if (bus.tx_data !== FILL) $display("FAIL uf_fill_byte got %h want %h", bus.tx_data, FILL); else n_pass++;
        // Third pulse consumes the fill byte while a clear is requested
        bus.byte_sent = 1'b1; clr_underflow = 1'b1; tick();
        bus.byte_sent = 1'b0;
        n_checks++; if (underflow !== 1'b1) $display("FAIL uf_set_wins got %b want 1", underflow); else n_pass++;
        tick();
        clr_underflow = 1'b0;
        n_checks++; if (underflow !== 1'b0) $display("FAIL uf_clear got %b want 0", underflow); else n_pass++;
        // One more word completes the frame: the fill byte did not count
        bus.in_valid = 1'b1; bus.in_data = 16'h0F0F; tick();
        bus.in_valid = 1'b0; tick();
        bus.byte_sent = 1'b1; tick(); bus.byte_sent = 1'b0;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL uf_early_done got %b want 0", frame_done); else n_pass++;
        tick();
        bus.byte_sent = 1'b1; tick(); bus.byte_sent = 1'b0;
        n_checks++; if (frame_done !== 1'b1) $display("FAIL uf_word_cnt_held got fd=%b want 1", frame_done); else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        apply_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_data = WORD_W'($urandom);
            tick();
        end
        n_checks++; if (level !== 5'(DEPTH)) $display("FAIL full_level got %0d want %0d", level, DEPTH); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (level !== 5'(DEPTH)) $display("FAIL full_hold got %0d want %0d", level, DEPTH); else n_pass++;
        bus.byte_sent = 1'b1; tick(); bus.byte_sent = 1'b0; tick();
        bus.byte_sent = 1'b1; tick();
        n_checks++; if (level !== 5'(DEPTH - 1))
            $display("FAIL full_pop_push got %0d want %0d", level, DEPTH - 1); else n_pass++;
        bus.byte_sent = 1'b0; bus.in_valid = 1'b0; tick();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL full_ready_again got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.tx_data !== m_txd) $display("FAIL full_tx_data got %h want %h", bus.tx_data, m_txd); else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_traffic(input string tag, input int cycles, input int push_pct,
                                input int sent_pct, input int word_limit);
        int  pushed;
        bit  exp_rdy;
        pushed = 0;
        for (int c = 0; c < cycles; c++) begin
            bus.in_valid  = (pushed < word_limit) && ($urandom_range(99) < push_pct);
            bus.in_data   = WORD_W'($urandom);
            bus.byte_sent = ($urandom_range(99) < sent_pct);
            clr_underflow = ($urandom_range(99) < 2);
            tick();
            if (m_pushed) pushed++;
            exp_rdy = m_ready();
            n_checks++; if (bus.tx_data !== m_txd)
                $display("FAIL %s_tx_data cyc %0d got %h want %h", tag, c, bus.tx_data, m_txd); else n_pass++;
            n_checks++; if (bus.tx_arm !== m_armed)
                $display("FAIL %s_tx_arm cyc %0d got %b want %b", tag, c, bus.tx_arm, m_armed); else n_pass++;
            n_checks++; if (level !== 5'(m_words()))
                $display("FAIL %s_level cyc %0d got %0d want %0d", tag, c, level, m_words()); else n_pass++;
            n_checks++; if (bus.in_ready !== exp_rdy)
                $display("FAIL %s_in_ready cyc %0d got %b want %b", tag, c, bus.in_ready, exp_rdy); else n_pass++;
            n_checks++; if (frame_done !== m_fd)
                $display("FAIL %s_frame_done cyc %0d got %b want %b", tag, c, frame_done, m_fd); else n_pass++;
            n_checks++; if (underflow !== m_under)
                $display("FAIL %s_underflow cyc %0d got %b want %b", tag, c, underflow, m_under); else n_pass++;
        end
        bus.in_valid  = 1'b0;
        bus.byte_sent = 1'b0;
        clr_underflow = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        test_traffic("wrap", 600, 100, 50, 40);
        n_checks++; if (level !== 5'd0) $display("FAIL wrap_drained got level %0d want 0", level); else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        test_traffic("rand_fill", 1500, 60, 30, 1 << 30);
        test_traffic("rand_drain", 1500, 25, 70, 1 << 30);
    endtask

    // ------------------------------------------------------------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.byte_sent = 1'b0;
        clr_underflow = 1'b0;
        model_reset();
        test_reset();
        test_split();
        test_frame();
        test_underflow();
        test_full();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_spi_tx_feeder
`default_nettype wire
